// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the data-memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_IFU  = 2'd1,
    OWNER_LSU  = 2'd2
  } owner_e;

  localparam int STARVE_LIMIT_DEF = 4;
  localparam int STARVE_CNT_W     = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Generic request/response memory bus; master issues requests, slave grants and responds.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [3:0]        wstrb;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata, wstrb,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, wstrb,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/mem_port_arbiter_prio.sv
// Combinational winner select: LSU beats IFU unless the IFU starvation guard has tripped.
module mem_port_prio
  import mem_port_arbiter_pkg::*;
(
  input  logic   i_ifu_req,
  input  logic   i_lsu_req,
  input  logic   i_starve_hit,
  output owner_e o_winner
);

  always_comb begin
    o_winner = OWNER_NONE;
    if (i_lsu_req && !(i_ifu_req && i_starve_hit)) begin
      o_winner = OWNER_LSU;
    end else if (i_ifu_req) begin
      o_winner = OWNER_IFU;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one data-memory port between IFU (read-only) and LSU; one transaction in flight.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  mem_port_arbiter_if.slave    ifu,
  mem_port_arbiter_if.slave    lsu,
  mem_port_arbiter_if.master   mem,
  output logic                 busy_o
);

  localparam logic [STARVE_CNT_W-1:0] LP_STARVE_LIMIT = 4'(STARVE_LIMIT);

  state_e                  r_state;
  state_e                  w_next_state;
  owner_e                  r_owner;
  owner_e                  w_winner_raw;
  owner_e                  w_winner;
  logic [STARVE_CNT_W-1:0] r_starve_cnt;
  logic                    w_starve_hit;
  logic                    w_arb_en;

  logic                    r_we;
  logic [ADDR_W-1:0]       r_addr;
  logic [DATA_W-1:0]       r_wdata;
  logic [3:0]              r_wstrb;

  logic                    w_ifu_gnt;
  logic                    w_lsu_gnt;
  logic                    w_ifu_rvalid;
  logic                    w_lsu_rvalid;
  logic [DATA_W-1:0]       w_ifu_rdata;
  logic [DATA_W-1:0]       w_lsu_rdata;
  logic                    w_mem_req;
  logic                    w_busy;

  // The IFU never writes, so its write-side bus fields are intentionally ignored.
  logic w_unused_ifu;
  assign w_unused_ifu = ^{ifu.we, ifu.wdata, ifu.wstrb};

  assign w_starve_hit = (r_starve_cnt == LP_STARVE_LIMIT);
  assign w_arb_en     = (r_state == IDLE) && rst_i;

  mem_port_prio u_prio (
    .i_ifu_req    (ifu.req),
    .i_lsu_req    (lsu.req),
    .i_starve_hit (w_starve_hit),
    .o_winner     (w_winner_raw)
  );

  assign w_winner = w_arb_en ? w_winner_raw : OWNER_NONE;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_winner != OWNER_NONE) w_next_state = REQ;
      REQ:     if (mem.gnt)                w_next_state = WAIT;
      WAIT:    if (mem.rvalid)             w_next_state = IDLE;
      default:                             w_next_state = IDLE;
    endcase
  end

  // Request fields are captured on the grant edge so the memory side sees them stable.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= 4'b0000;
      r_owner      <= OWNER_NONE;
      r_starve_cnt <= '0;
    end else if (w_winner == OWNER_LSU) begin
      r_we    <= lsu.we;
      r_addr  <= lsu.addr;
      r_wdata <= lsu.wdata;
      r_wstrb <= lsu.wstrb;
      r_owner <= OWNER_LSU;
      if (!ifu.req) begin
        r_starve_cnt <= '0;
      end else if (!w_starve_hit) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
    end else if (w_winner == OWNER_IFU) begin
      r_we         <= 1'b0;
      r_addr       <= ifu.addr;
      r_wdata      <= '0;
      r_wstrb      <= 4'b1111;
      r_owner      <= OWNER_IFU;
      r_starve_cnt <= '0;
    end
  end

  always_comb begin
    w_ifu_gnt    = (w_winner == OWNER_IFU);
    w_lsu_gnt    = (w_winner == OWNER_LSU);
    w_mem_req    = (r_state == REQ);
    w_busy       = (r_state != IDLE);
    w_ifu_rvalid = 1'b0;
    w_lsu_rvalid = 1'b0;
    w_ifu_rdata  = '0;
    w_lsu_rdata  = '0;
    if ((r_state == WAIT) && mem.rvalid) begin
      if (r_owner == OWNER_IFU) begin
        w_ifu_rvalid = 1'b1;
        w_ifu_rdata  = mem.rdata;
      end else if (r_owner == OWNER_LSU) begin
        w_lsu_rvalid = 1'b1;
        w_lsu_rdata  = mem.rdata;
      end
    end
  end

  assign ifu.gnt    = w_ifu_gnt;
  assign ifu.rvalid = w_ifu_rvalid;
  assign ifu.rdata  = w_ifu_rdata;
  assign lsu.gnt    = w_lsu_gnt;
  assign lsu.rvalid = w_lsu_rvalid;
  assign lsu.rdata  = w_lsu_rdata;

  assign mem.req    = w_mem_req;
  assign mem.we     = r_we;
  assign mem.addr   = r_addr;
  assign mem.wdata  = r_wdata;
  assign mem.wstrb  = r_wstrb;

  assign busy_o     = w_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with hand-computed expectations.
module tb_mem_port_arbiter;

  logic clk;
  logic rstN;
  logic busy;
  int   testsRun;
  int   testsFailed;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifuBus ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) lsuBus ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) memBus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk_i  (clk),
    .rst_i  (rstN),
    .ifu    (ifuBus),
    .lsu    (lsuBus),
    .mem    (memBus),
    .busy_o (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ifuReq, input logic [31:0] ifuAddr,
                               input logic lsuReq, input logic lsuWe, input logic [31:0] lsuAddr,
                               input logic [31:0] lsuWdata, input logic [3:0] lsuWstrb);
    ifuBus.req   = ifuReq;
    ifuBus.addr  = ifuAddr;
    lsuBus.req   = lsuReq;
    lsuBus.we    = lsuWe;
    lsuBus.addr  = lsuAddr;
    lsuBus.wdata = lsuWdata;
    lsuBus.wstrb = lsuWstrb;
  endtask

  task automatic setMem(input logic gnt, input logic rvalid, input logic [31:0] rdata);
    memBus.gnt    = gnt;
    memBus.rvalid = rvalid;
    memBus.rdata  = rdata;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic expIfu [10];

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    expIfu      = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    rstN         = 1'b0;
    ifuBus.we    = 1'b0;
    ifuBus.wdata = 32'h0;
    ifuBus.wstrb = 4'h0;
    applyStimulus(1'b1, 32'h8000_0000, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    setMem(1'b0, 1'b0, 32'h0);

    // Reset: requests present but every output must stay low
    nextCycle(); settle();
    checkOutput("rstIfuGnt", 64'(ifuBus.gnt), 64'd0);
    checkOutput("rstLsuGnt", 64'(lsuBus.gnt), 64'd0);
    checkOutput("rstMemReq", 64'(memBus.req), 64'd0);
    checkOutput("rstMemAddr", 64'(memBus.addr), 64'd0);
    checkOutput("rstBusy", 64'(busy), 64'd0);
    nextCycle();
    rstN = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    settle();
    checkOutput("idleBusy", 64'(busy), 64'd0);

    // IFU-only read
    nextCycle();
    applyStimulus(1'b1, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    settle();
    checkOutput("s1GntIfu", 64'(ifuBus.gnt), 64'd1);
    checkOutput("s1GntLsu", 64'(lsuBus.gnt), 64'd0);
    checkOutput("s1MemReqC0", 64'(memBus.req), 64'd0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    setMem(1'b1, 1'b0, 32'h0);
    settle();
    checkOutput("s1MemReq", 64'(memBus.req), 64'd1);
    checkOutput("s1MemAddr", 64'(memBus.addr), 64'h8000_0000);
    checkOutput("s1MemWe", 64'(memBus.we), 64'd0);
    checkOutput("s1MemWstrb", 64'(memBus.wstrb), 64'hF);
    checkOutput("s1MemWdata", 64'(memBus.wdata), 64'd0);
    nextCycle();
    setMem(1'b0, 1'b0, 32'h0);
    settle();
    checkOutput("s1BusyWait", 64'(busy), 64'd1);
    checkOutput("s1MemReqWait", 64'(memBus.req), 64'd0);
    checkOutput("s1IfuRvEarly", 64'(ifuBus.rvalid), 64'd0);
    nextCycle();
    setMem(1'b0, 1'b1, 32'h0000_0413);
    settle();
    checkOutput("s1IfuRv", 64'(ifuBus.rvalid), 64'd1);
    checkOutput("s1IfuRdata", 64'(ifuBus.rdata), 64'h0000_0413);
    checkOutput("s1LsuRv", 64'(lsuBus.rvalid), 64'd0);
    checkOutput("s1LsuRdata", 64'(lsuBus.rdata), 64'd0);
    nextCycle();
    setMem(1'b0, 1'b0, 32'h0);
    settle();
    checkOutput("s1BusyDone", 64'(busy), 64'd0);

    // LSU byte write
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h8000_1003, 32'hAB00_0000, 4'b1000);
    settle();
    checkOutput("s2GntLsu", 64'(lsuBus.gnt), 64'd1);
    checkOutput("s2GntIfu", 64'(ifuBus.gnt), 64'd0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    setMem(1'b1, 1'b0, 32'h0);
    settle();
    checkOutput("s2MemReq", 64'(memBus.req), 64'd1);
    checkOutput("s2MemWe", 64'(memBus.we), 64'd1);
    checkOutput("s2MemAddr", 64'(memBus.addr), 64'h8000_1003);
    checkOutput("s2MemWdata", 64'(memBus.wdata), 64'hAB00_0000);
    checkOutput("s2MemWstrb", 64'(memBus.wstrb), 64'h8);
    nextCycle();
    setMem(1'b0, 1'b0, 32'h0);
    settle();
    checkOutput("s2LsuRvEarly", 64'(lsuBus.rvalid), 64'd0);
    nextCycle();
    setMem(1'b0, 1'b1, 32'hDEAD_BEEF);
    settle();
    checkOutput("s2LsuAck", 64'(lsuBus.rvalid), 64'd1);
    checkOutput("s2LsuRdata", 64'(lsuBus.rdata), 64'hDEAD_BEEF);
    checkOutput("s2IfuRv", 64'(ifuBus.rvalid), 64'd0);
    checkOutput("s2IfuRdata", 64'(ifuBus.rdata), 64'd0);
    checkOutput("s2BusyAck", 64'(busy), 64'd1);
    nextCycle();
    setMem(1'b0, 1'b0, 32'h0);
    settle();
    checkOutput("s2BusyDone", 64'(busy), 64'd0);

    // Both requests held: L L L L I L L L L I
    applyStimulus(1'b1, 32'h8000_0100, 1'b1, 1'b0, 32'h0000_2000, 32'h0, 4'hF);
    for (int i = 0; i < 10; i++) begin
      settle();
      checkOutput($sformatf("s3GntIfu%0d", i), 64'(ifuBus.gnt), 64'(expIfu[i]));
      checkOutput($sformatf("s3GntLsu%0d", i), 64'(lsuBus.gnt), 64'(!expIfu[i]));
      nextCycle();
      setMem(1'b1, 1'b0, 32'h0);
      settle();
      checkOutput($sformatf("s3Addr%0d", i), 64'(memBus.addr),
                  expIfu[i] ? 64'h8000_0100 : 64'h0000_2000);
      checkOutput($sformatf("s3ReqGnt%0d", i), 64'(ifuBus.gnt | lsuBus.gnt), 64'd0);
      nextCycle();
      setMem(1'b0, 1'b0, 32'h0);
      settle();
      checkOutput($sformatf("s3WaitGnt%0d", i), 64'(ifuBus.gnt | lsuBus.gnt), 64'd0);
      nextCycle();
      setMem(1'b0, 1'b1, 32'(i + 100));
      settle();
      checkOutput($sformatf("s3IfuRv%0d", i), 64'(ifuBus.rvalid), 64'(expIfu[i]));
      checkOutput($sformatf("s3LsuRv%0d", i), 64'(lsuBus.rvalid), 64'(!expIfu[i]));
      nextCycle();
      setMem(1'b0, 1'b0, 32'h0);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    settle();
    checkOutput("s3BusyDone", 64'(busy), 64'd0);

    // Memory stall: 5 cycles without mem_gnt while IFU waits
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0100, 32'h1122_3344, 4'b0011);
    settle();
    checkOutput("s4GntLsu", 64'(lsuBus.gnt), 64'd1);
    for (int c = 1; c <= 6; c++) begin
      nextCycle();
      applyStimulus(1'b1, 32'h8000_0200, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
      setMem((c == 6), 1'b0, 32'h0);
      settle();
      checkOutput($sformatf("s4Req%0d", c), 64'(memBus.req), 64'd1);
      checkOutput($sformatf("s4Fields%0d", c),
                  {memBus.addr[15:0], memBus.wdata, 11'd0, memBus.we, memBus.wstrb},
                  {16'h0100, 32'h1122_3344, 11'd0, 1'b1, 4'b0011});
      checkOutput($sformatf("s4NoGnt%0d", c), 64'(ifuBus.gnt | lsuBus.gnt), 64'd0);
    end
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    setMem(1'b0, 1'b0, 32'h0);
    settle();
    checkOutput("s4MemReqWait", 64'(memBus.req), 64'd0);
    nextCycle();
    setMem(1'b0, 1'b1, 32'h0);
    settle();
    checkOutput("s4LsuAck", 64'(lsuBus.rvalid), 64'd1);
    nextCycle();
    setMem(1'b0, 1'b0, 32'h0);
    settle();
    checkOutput("s4BusyDone", 64'(busy), 64'd0);

    // Stray response in IDLE
    setMem(1'b0, 1'b1, 32'h5555_5555);
    settle();
    checkOutput("s5IdleIfuRv", 64'(ifuBus.rvalid), 64'd0);
    checkOutput("s5IdleLsuRv", 64'(lsuBus.rvalid), 64'd0);
    nextCycle();
    setMem(1'b0, 1'b0, 32'h0);
    settle();
    checkOutput("s5IdleBusy", 64'(busy), 64'd0);
    // Stray response in REQ
    applyStimulus(1'b1, 32'h8000_0300, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    settle();
    checkOutput("s5GntIfu", 64'(ifuBus.gnt), 64'd1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    setMem(1'b0, 1'b1, 32'h6666_6666);
    settle();
    checkOutput("s5ReqIfuRv", 64'(ifuBus.rvalid), 64'd0);
    checkOutput("s5ReqIfuRdata", 64'(ifuBus.rdata), 64'd0);
    nextCycle();
    setMem(1'b1, 1'b0, 32'h0);
    settle();
    checkOutput("s5StillReq", 64'(memBus.req), 64'd1);
    nextCycle();
    setMem(1'b0, 1'b0, 32'h0);
    nextCycle();
    setMem(1'b0, 1'b1, 32'h0000_0777);
    settle();
    checkOutput("s5IfuRv", 64'(ifuBus.rvalid), 64'd1);
    checkOutput("s5IfuRdata", 64'(ifuBus.rdata), 64'h0000_0777);
    nextCycle();
    setMem(1'b0, 1'b0, 32'h0);

    // Reset in WAIT discards the in-flight response
    applyStimulus(1'b1, 32'h8000_0400, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    settle();
    checkOutput("s6GntIfu", 64'(ifuBus.gnt), 64'd1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    setMem(1'b1, 1'b0, 32'h0);
    nextCycle();
    setMem(1'b0, 1'b0, 32'h0);
    rstN = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    settle();
    checkOutput("s6RstBusy", 64'(busy), 64'd0);
    checkOutput("s6RstMemAddr", 64'(memBus.addr), 64'd0);
    checkOutput("s6RstLsuGnt", 64'(lsuBus.gnt), 64'd0);
    nextCycle();
    rstN = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    setMem(1'b0, 1'b1, 32'h0000_0BAD);
    settle();
    checkOutput("s6StrayIfuRv", 64'(ifuBus.rvalid), 64'd0);
    checkOutput("s6StrayBusy", 64'(busy), 64'd0);
    nextCycle();
    setMem(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h8000_0080, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    settle();
    checkOutput("s6NextGnt", 64'(ifuBus.gnt), 64'd1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    setMem(1'b1, 1'b0, 32'h0);
    settle();
    checkOutput("s6NextAddr", 64'(memBus.addr), 64'h8000_0080);
    nextCycle();
    setMem(1'b0, 1'b0, 32'h0);
    nextCycle();
    setMem(1'b0, 1'b1, 32'h1234_5678);
    settle();
    checkOutput("s6NextRdata", 64'(ifuBus.rdata), 64'h1234_5678);
    nextCycle();
    setMem(1'b0, 1'b0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
